// File: rtl/spi_slave_top.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_top
//  Description : SPI slave front-end with a MEM_DEPTH x 8 single-port RAM.
//                The master sends 10-bit frames {cmd[1:0], payload[7:0]},
//                MSB first, while SS_n is low:
//                  00 set write address   01 write data at write address
//                  10 set read address    11 read data, shifted out on MISO
//                Optional feature macro: RD_ADDR_AUTOINC_EN
//                  (read address post-increments after each completed read).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_top #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        EXEC = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam logic [1:0] c_CMD_WADDR = 2'b00;
    localparam logic [1:0] c_CMD_WDATA = 2'b01;
    localparam logic [1:0] c_CMD_RADDR = 2'b10;
    localparam logic [3:0] c_RX_LAST   = 4'd9;   // index of the 10th frame bit
    localparam logic [3:0] c_TX_LAST   = 4'd7;   // index of the 8th read bit

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [9:0]             r_shift;
    logic [9:0]             w_shift_nxt;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    logic [ADDR_SIZE-1:0]   w_rd_addr_nxt;
    logic [7:0]             r_tx;
    logic [7:0]             w_tx_nxt;
    logic                   w_mem_we;
    logic [7:0]             r_mem [0:MEM_DEPTH-1];

    // Address field of the received frame (low ADDR_SIZE bits of the payload)
    logic [ADDR_SIZE-1:0]   w_payload_addr;
    assign w_payload_addr = r_shift[ADDR_SIZE-1:0];

    // MISO carries the tx MSB only while a read is being shifted out
    assign MISO = (r_state == SEND) ? r_tx[7] : 1'b0;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 10'd0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_tx      <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // RAM write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= r_shift[7:0];
        end
    end

    // Next-state and datapath decode; SS_n high outside IDLE aborts with no side effects
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_wr_addr_nxt = r_wr_addr;
        w_rd_addr_nxt = r_rd_addr;
        w_tx_nxt      = r_tx;
        w_mem_we      = 1'b0;

        case (r_state)
            IDLE: begin
                // MOSI is not sampled here; the first frame bit arrives next edge
                if (!SS_n) begin
                    w_state_nxt = RECV;
                    w_cnt_nxt   = 4'd0;
                end
            end

            RECV: begin
                if (SS_n) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_shift_nxt = {r_shift[8:0], MOSI};
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == c_RX_LAST) begin
                        w_state_nxt = EXEC;
                    end
                end
            end

            EXEC: begin
                w_state_nxt = IDLE;
                if (!SS_n) begin
                    case (r_shift[9:8])
                        c_CMD_WADDR: w_wr_addr_nxt = w_payload_addr;
                        c_CMD_WDATA: w_mem_we      = 1'b1;
                        c_CMD_RADDR: w_rd_addr_nxt = w_payload_addr;
                        default: begin
                            // Read: payload is a dummy byte
                            w_tx_nxt    = r_mem[r_rd_addr];
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = SEND;
                        end
                    endcase
                end
            end

            SEND: begin
                if (SS_n) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_tx_nxt  = {r_tx[6:0], 1'b0};
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == c_TX_LAST) begin
                        w_state_nxt = IDLE;
`ifdef RD_ADDR_AUTOINC_EN
                        // Completed read: advance for streaming, wrapping at MEM_DEPTH
                        if (r_rd_addr == ADDR_SIZE'(MEM_DEPTH - 1)) begin
                            w_rd_addr_nxt = '0;
                        end else begin
                            w_rd_addr_nxt = r_rd_addr + ADDR_SIZE'(1);
                        end
`else
                        w_rd_addr_nxt = r_rd_addr;
`endif
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_top
//  Description : Directed self-checking bench for spi_slave_top. Honours
//                RD_ADDR_AUTOINC_EN when compiled with that macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_top;

    logic clk;
    logic rst;
    logic MOSI;
    logic MISO;
    logic SS_n;

    int n_checks;
    int n_fails;

    spi_slave_top #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .MOSI (MOSI),
        .MISO (MISO),
        .SS_n (SS_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle edge plus 10 bit edges; leaves the DUT in EXEC
    task automatic send_frame(input logic [9:0] f);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            tick();
        end
        MOSI = 1'b0;
    endtask

    // Full non-read frame including its EXEC edge
    task automatic wr_frame(input logic [9:0] f);
        send_frame(f);
        tick();
    endtask

    // Read frame: MISO low in EXEC, 8 data bits MSB first, low again afterwards
    task automatic read_check(input string tag, input logic [7:0] exp);
        logic [7:0] e;
        e = exp;
        send_frame({2'b11, 8'hFF});
        check({tag, "_pre"}, {7'd0, MISO}, 8'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_bit%0d", tag, i), {7'd0, MISO}, {7'd0, e[7-i]});
            tick();
        end
        check({tag, "_post"}, {7'd0, MISO}, 8'd0);
    endtask

    initial begin
        logic [9:0] f;
        n_checks = 0;
        n_fails  = 0;
        rst  = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_miso", {7'd0, MISO}, 8'd0);
        check("rst_wr_addr", dut.r_wr_addr, 8'h00);
        check("rst_rd_addr", dut.r_rd_addr, 8'h00);
        tick();
        tick();
        check("idle_miso", {7'd0, MISO}, 8'd0);

        // Write 0x90 to 0x50 and read it back
        wr_frame({2'b00, 8'h50});
        check("wr_addr_set", dut.r_wr_addr, 8'h50);
        wr_frame({2'b01, 8'h90});
        wr_frame({2'b10, 8'h50});
        check("rd_addr_set", dut.r_rd_addr, 8'h50);
        read_check("rd50", 8'h90);

        // Abort a data write after 6 bits: memory must keep 0x90
        f = {2'b01, 8'hAA};
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        for (int i = 9; i >= 4; i--) begin
            MOSI = f[i];
            tick();
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        check("abort_miso", {7'd0, MISO}, 8'd0);
        check("abort_wr_addr", dut.r_wr_addr, 8'h50);
        tick();

        // Abort during EXEC: address must not change
        send_frame({2'b00, 8'h77});
        SS_n = 1'b1;
        tick();
        check("exec_abort_wr_addr", dut.r_wr_addr, 8'h50);
        tick();

        wr_frame({2'b10, 8'h50});
        read_check("rd50_after_abort", 8'h90);

        // Last write wins, write address persists between data frames
        wr_frame({2'b00, 8'h20});
        wr_frame({2'b01, 8'h11});
        wr_frame({2'b01, 8'h22});
        wr_frame({2'b10, 8'h20});
        read_check("rd20_last", 8'h22);

        // Boundary addresses
        wr_frame({2'b00, 8'hFF});
        wr_frame({2'b01, 8'hA5});
        wr_frame({2'b00, 8'h00});
        wr_frame({2'b01, 8'h3C});
        wr_frame({2'b10, 8'hFF});
        read_check("rdFF", 8'hA5);
        wr_frame({2'b10, 8'h00});
        read_check("rd00", 8'h3C);

        // Back-to-back reads from 0xFF
        wr_frame({2'b10, 8'hFF});
        read_check("stream0", 8'hA5);
`ifdef RD_ADDR_AUTOINC_EN
        read_check("stream1", 8'h3C);
        check("stream_rd_addr", dut.r_rd_addr, 8'h01);
`else
        read_check("stream1", 8'hA5);
        check("stream_rd_addr", dut.r_rd_addr, 8'hFF);
`endif

        // Aborted read: no increment, MISO back to 0
        wr_frame({2'b10, 8'h50});
        send_frame({2'b11, 8'hFF});
        tick();
        tick();
        SS_n = 1'b1;
        tick();
        check("send_abort_miso", {7'd0, MISO}, 8'd0);
        check("send_abort_rd_addr", dut.r_rd_addr, 8'h50);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_top.md
Name: spi_slave_top

Overview:
- SPI slave front-end plus single-port RAM (MEM_DEPTH x 8), one clock domain.
- Master sends 10-bit frames on MOSI while SS_n is low: 2-bit command plus 8-bit payload.
- Commands write the RAM or read it back; read data is shifted out on MISO.
- Top-level memory-mapped peripheral behind an SPI pin interface.

Parameters:
- MEM_DEPTH, 256: number of 8-bit RAM words.
- ADDR_SIZE, 8: address width. Only the payload's low ADDR_SIZE bits are used as the address. Requires ADDR_SIZE <= 8 and MEM_DEPTH <= 2**ADDR_SIZE.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- MOSI, input, 1: serial data from master, MSB first.
- MISO, output, 1: serial data to master.
- SS_n, input, 1: slave select, active-low.

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE, MISO=0, bit counter=0, shift register=0, wr_addr=0, rd_addr=0, tx register=0.
  - RAM contents unchanged.
- States: IDLE, RECV, EXEC, SEND.
- IDLE:
  - SS_n=0 -> RECV, counter cleared.
  - MOSI is not sampled on this edge.
- RECV:
  - On each edge, shift_reg <= {shift_reg[8:0], MOSI}; counter increments.
  - After the 10th sampled bit -> EXEC.
- EXEC (one cycle; frame = cmd[9:8], payload[7:0]):
  - 00: wr_addr <= payload; -> IDLE.
  - 01: mem[wr_addr] <= payload; -> IDLE.
  - 10: rd_addr <= payload; -> IDLE.
  - 11: tx <= mem[rd_addr]; payload is dummy and ignored; -> SEND.
- SEND:
  - 8 cycles. MISO = tx[7] during each cycle; tx shifts left one bit per edge.
  - After the 8th bit -> IDLE.
- MISO: 0 in every state except SEND.
- SS_n=1 sampled in RECV, EXEC or SEND:
  - -> IDLE on that edge; frame aborted.
  - No RAM write or address update occurs, even in EXEC.
  - wr_addr and rd_addr keep their old values.
- Frame timing:
  - SS_n may stay low across frames.
  - After the 10th bit the master leaves two unsampled clocks (EXEC, IDLE) before the next command bit.
  - For cmd 11, the master clocks 8 more cycles to receive data, then the same two-cycle gap applies.
- Write to the same address repeatedly: last write wins.
- Read of a never-written address returns RAM power-up content (X in simulation).

Optional Feature:
- Macro: RD_ADDR_AUTOINC_EN.
- Defined: on normal completion of SEND, rd_addr <= rd_addr+1, wrapping modulo MEM_DEPTH, so consecutive 11 frames stream sequential words. An aborted SEND does not increment.
- Undefined: rd_addr changes only via cmd 10 or reset.

Test Plan:
- Reset: rst=1 one edge with SS_n=1 -> MISO=0, state IDLE, wr_addr=rd_addr=0.
- Write: SS_n=0; frames 00_0101_0000 then 01_1001_0000, each followed by 2 gap cycles -> mem[0x50]=0x90.
- Read-back: frames 10_0101_0000 then 11_1111_1111 -> MISO = 1,0,0,1,0,0,0,0 on the 8 cycles after EXEC; MISO=0 before and after.
- Abort: start 01_1010_1010 to wr_addr 0x50, raise SS_n after 6 bits -> mem[0x50] stays 0x90; next full frame works normally.
- Address wrap/boundary: write 0xA5 to 0xFF and 0x3C to 0x00, read both -> 1010_0101 and 0011_1100.
- With RD_ADDR_AUTOINC_EN: rd_addr=0xFF, two 11 frames -> 0xA5 then 0x3C (wrap to 0x00). Without the macro, both reads return 0xA5.
